// File: rtl/logic_reduce_pkg.sv
// logic_reduce_pkg: shared definitions for the pipelined reduction gate.
//   - op encoding constants (OP_OR .. OP_XNOR; 6 and 7 are illegal)
//   - gate_e: the 2-input gate type used by every tree level
//   - base_op / invert_op / identity: decode an op into gate type,
//     final inversion flag and the pad bit used for an odd leftover bit
//   - clog2 / level_w: stage count and per-level vector width
package logic_reduce_pkg;

  localparam logic [2:0] OP_OR   = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    GATE_OR  = 2'd0,
    GATE_AND = 2'd1,
    GATE_XOR = 2'd2
  } gate_e;

  function automatic gate_e base_op(input logic [2:0] op);
    gate_e g;
    case (op)
      OP_AND, OP_NAND: g = GATE_AND;
      OP_XOR, OP_XNOR: g = GATE_XOR;
      default:         g = GATE_OR;
    endcase
    return g;
  endfunction

  function automatic logic invert_op(input logic [2:0] op);
    return (op == OP_NOR) || (op == OP_NAND) || (op == OP_XNOR);
  endfunction

  // Pad bit for an odd leftover: neutral element of the base gate.
  function automatic logic identity(input logic [2:0] op);
    return (base_op(op) == GATE_AND);
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Vector width after k tree levels: ceil(w / 2^k).
  function automatic int level_w(input int w, input int k);
    return (w + (1 << k) - 1) >> k;
  endfunction

endpackage

// File: rtl/logic_reduce_pipe_stage.sv
// reduce_stage: one level of the reduction tree plus its register.
// Pairs adjacent bits through 2-input gates of the base function, padding
// an odd leftover with the identity element, and registers the result
// together with valid, op and err. The LAST instance also applies the
// NOR/NAND/XNOR inversion and forces the result to 0 for illegal ops,
// so the block output is registered and glitch-free.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              global advance enable
//   vec/valid/op/err          level input
//   vec_q/valid_q/op_q/err_q  registered level output
module reduce_stage
  import logic_reduce_pkg::*;
#(
  parameter int IN_W = 2,
  parameter bit LAST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [IN_W-1:0]          vec,
  input  logic                     valid,
  input  logic [2:0]               op,
  input  logic                     err,
  output logic [(IN_W+1)/2-1:0]    vec_q,
  output logic                     valid_q,
  output logic [2:0]               op_q,
  output logic                     err_q
);

  localparam int OUT_W = (IN_W + 1) / 2;

  logic [2*OUT_W-1:0] padded;
  logic [OUT_W-1:0]   gated;
  logic [OUT_W-1:0]   nxt;
  gate_e              gate;

  always_comb begin
    gate   = base_op(op);
    padded = {(2*OUT_W){identity(op)}};
    padded[IN_W-1:0] = vec;
    gated  = '0;
    for (int i = 0; i < OUT_W; i++) begin
      case (gate)
        GATE_AND: gated[i] = padded[2*i] & padded[2*i+1];
        GATE_XOR: gated[i] = padded[2*i] ^ padded[2*i+1];
        default:  gated[i] = padded[2*i] | padded[2*i+1];
      endcase
    end
    nxt = gated;
    if (LAST) begin
      nxt = err ? '0 : (gated ^ {OUT_W{invert_op(op)}});
    end
  end

  // Bubbles load zeros so undriven data/op never reach the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      vec_q   <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
    end else if (en) begin
      valid_q <= valid;
      vec_q   <= valid ? nxt : '0;
      op_q    <= valid ? op : 3'd0;
      err_q   <= valid & err;
    end
  end

endmodule

// File: rtl/logic_reduce_pipe.sv
// logic_reduce_pipe: pipelined WIDTH-input reduction gate (OR, AND, XOR,
// NOR, NAND, XNOR selected per item). A binary tree of clog2(WIDTH)
// registered levels; latency clog2(WIDTH) edges, throughput 1 item/cycle.
// Handshake: a transfer happens on a rising edge where valid && ready.
//   in_ready = !out_valid || out_ready (combinational). When it is high
//   every level loads from its predecessor at once; bubbles are kept.
//   A source seeing in_ready=0 must hold in_data/in_op.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid, in_ready         input handshake
//   in_data[WIDTH-1:0], in_op  vector and operation (6/7 illegal)
//   out_valid, out_ready       output handshake
//   out_y, out_err             result and illegal-op flag
module logic_reduce_pipe
  import logic_reduce_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
  output logic             out_err
);

  localparam int S = clog2(WIDTH);

  logic adv;
  logic in_err;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign in_err   = (in_op > OP_XNOR);

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int IW = level_w(WIDTH, k);
    localparam int OW = level_w(WIDTH, k + 1);

    logic [IW-1:0] vec_d;
    logic          valid_d;
    logic [2:0]    op_d;
    logic          err_d;
    logic [OW-1:0] vec_q;
    logic          valid_q;
    logic [2:0]    op_q;
    logic          err_q;

    if (k == 0) begin : g_src
      assign vec_d   = in_data;
      assign valid_d = in_valid;
      assign op_d    = in_op;
      assign err_d   = in_err;
    end else begin : g_src
      assign vec_d   = g_stage[k-1].vec_q;
      assign valid_d = g_stage[k-1].valid_q;
      assign op_d    = g_stage[k-1].op_q;
      assign err_d   = g_stage[k-1].err_q;
    end

    reduce_stage #(
      .IN_W (IW),
      .LAST ((k == S - 1) ? 1'b1 : 1'b0)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (adv),
      .vec     (vec_d),
      .valid   (valid_d),
      .op      (op_d),
      .err     (err_d),
      .vec_q   (vec_q),
      .valid_q (valid_q),
      .op_q    (op_q),
      .err_q   (err_q)
    );
  end

  assign out_valid = g_stage[S-1].valid_q;
  assign out_y     = g_stage[S-1].vec_q[0];
  assign out_err   = g_stage[S-1].err_q;

  // The op has been fully applied by the last level.
  logic unused_op;
  assign unused_op = ^g_stage[S-1].op_q;

endmodule

// File: tb/tb_logic_reduce_pipe.sv
module tb_logic_reduce_pipe;
  import logic_reduce_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic       in_valid8, in_ready8, out_valid8, out_ready8, out_y8, out_err8;
  logic [7:0] in_data8;
  logic [2:0] in_op8;
  logic       in_valid5, in_ready5, out_valid5, out_ready5, out_y5, out_err5;
  logic [4:0] in_data5;
  logic [2:0] in_op5;

  logic_reduce_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_op(in_op8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_y(out_y8), .out_err(out_err8)
  );

  logic_reduce_pipe #(.WIDTH(5)) u_dut5 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5), .in_op(in_op5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_y(out_y5), .out_err(out_err5)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q8[$];
  logic [1:0] exp_q5[$];
  int pop_cyc8[$];
  int pop_cyc5[$];
  logic [1:0] e8, e5;

  // Reference: count ones, then apply the op's meaning. Returns {err, y}.
  function automatic logic [1:0] model(input logic [63:0] d, input int w, input logic [2:0] op);
    int ones;
    logic y;
    ones = 0;
    for (int i = 0; i < w; i++) ones += int'(d[i]);
    case (op)
      3'd0: y = (ones > 0);
      3'd1: y = (ones == w);
      3'd2: y = (ones % 2 == 1);
      3'd3: y = (ones == 0);
      3'd4: y = (ones != w);
      3'd5: y = (ones % 2 == 0);
      default: return 2'b10;
    endcase
    return {1'b0, y};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: samples 1 time unit before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (out_valid8 && out_ready8) begin
      pop_cyc8.push_back(cyc);
      checks++;
      if (exp_q8.size() == 0) begin
        errors++;
        $display("FAIL sb8 unexpected output err/y=%b%b exp=none", out_err8, out_y8);
      end else begin
        e8 = exp_q8.pop_front();
        if ({out_err8, out_y8} !== e8) begin
          errors++;
          $display("FAIL sb8 err/y got=%b%b exp=%b", out_err8, out_y8, e8);
        end
      end
    end
    if (out_valid5 && out_ready5) begin
      pop_cyc5.push_back(cyc);
      checks++;
      if (exp_q5.size() == 0) begin
        errors++;
        $display("FAIL sb5 unexpected output err/y=%b%b exp=none", out_err5, out_y5);
      end else begin
        e5 = exp_q5.pop_front();
        if ({out_err5, out_y5} !== e5) begin
          errors++;
          $display("FAIL sb5 err/y got=%b%b exp=%b", out_err5, out_y5, e5);
        end
      end
    end
  end

  // ---------------- drivers (called at a falling edge) ----------------
  task automatic push8(input logic [7:0] d, input logic [2:0] op, input logic [1:0] e);
    int b;
    b = 0;
    in_valid8 = 1'b1; in_data8 = d; in_op8 = op;
    #1;
    while (!in_ready8 && b < 100) begin @(negedge clk); #1; b++; end
    if (!in_ready8) begin
      checks++; errors++;
      $display("FAIL push8_timeout in_ready=%b exp=1", in_ready8);
    end else exp_q8.push_back(e);
    @(negedge clk);
    in_valid8 = 1'b0;
  endtask

  task automatic push5(input logic [4:0] d, input logic [2:0] op, input logic [1:0] e);
    int b;
    b = 0;
    in_valid5 = 1'b1; in_data5 = d; in_op5 = op;
    #1;
    while (!in_ready5 && b < 100) begin @(negedge clk); #1; b++; end
    if (!in_ready5) begin
      checks++; errors++;
      $display("FAIL push5_timeout in_ready=%b exp=1", in_ready5);
    end else exp_q5.push_back(e);
    @(negedge clk);
    in_valid5 = 1'b0;
  endtask

  task automatic drain(input string name);
    int b;
    b = 0;
    while ((exp_q8.size() != 0 || exp_q5.size() != 0) && b < 300) begin
      @(negedge clk);
      b++;
    end
    @(negedge clk);
    check(name, 64'(exp_q8.size() + exp_q5.size()), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic       exp_err;
    logic       exp_y;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    logic seen;
    logic pend8, pend5;

    tbl[0]  = '{OP_OR,   8'h00, 1'b0, 1'b0};
    tbl[1]  = '{OP_OR,   8'h01, 1'b0, 1'b1};
    tbl[2]  = '{OP_OR,   8'h80, 1'b0, 1'b1};
    tbl[3]  = '{OP_AND,  8'hFF, 1'b0, 1'b1};
    tbl[4]  = '{OP_NAND, 8'hFF, 1'b0, 1'b0};
    tbl[5]  = '{OP_XOR,  8'h07, 1'b0, 1'b1};
    tbl[6]  = '{OP_XNOR, 8'h07, 1'b0, 1'b0};
    tbl[7]  = '{OP_NOR,  8'h00, 1'b0, 1'b1};
    tbl[8]  = '{3'd6,    8'hFF, 1'b1, 1'b0};
    tbl[9]  = '{OP_OR,   8'h01, 1'b0, 1'b1};
    tbl[10] = '{3'd7,    8'h00, 1'b1, 1'b0};
    tbl[11] = '{OP_AND,  8'hFE, 1'b0, 1'b0};
    tbl[12] = '{OP_NAND, 8'h00, 1'b0, 1'b1};
    tbl[13] = '{OP_XNOR, 8'h00, 1'b0, 1'b1};
    tbl[14] = '{OP_XOR,  8'hFF, 1'b0, 1'b0};
    tbl[15] = '{OP_NOR,  8'h10, 1'b0, 1'b0};

    in_valid8 = 1'b0; in_data8 = '0; in_op8 = '0; out_ready8 = 1'b1;
    in_valid5 = 1'b0; in_data5 = '0; in_op5 = '0; out_ready5 = 1'b1;

    // Reset state
    @(negedge clk); #1;
    check("reset_out_valid8", 64'(out_valid8), 64'd0);
    check("reset_out_y8",     64'(out_y8),     64'd0);
    check("reset_out_err8",   64'(out_err8),   64'd0);
    check("reset_in_ready8",  64'(in_ready8),  64'd1);
    check("reset_out_valid5", 64'(out_valid5), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table: back-to-back, incl. OR sweep, mixed ops and illegal ops
    acc = cyc;
    pop_cyc8.delete();
    for (int i = 0; i < 16; i++) push8(tbl[i].data, tbl[i].op, {tbl[i].exp_err, tbl[i].exp_y});
    drain("table_drain");
    check("table_pops",  64'(pop_cyc8.size()), 64'd16);
    check("lat8_first",  64'(pop_cyc8.size() > 0 ? pop_cyc8[0] : -1), 64'(acc + 3));
    check("lat8_second", 64'(pop_cyc8.size() > 1 ? pop_cyc8[1] : -1), 64'(acc + 4));
    check("lat8_third",  64'(pop_cyc8.size() > 2 ? pop_cyc8[2] : -1), 64'(acc + 5));

    // Padding on the 5-bit instance
    acc = cyc;
    pop_cyc5.delete();
    push5(5'h1F, OP_AND, 2'b01);
    push5(5'h00, OP_OR,  2'b00);
    push5(5'h10, OP_XOR, 2'b01);
    drain("pad_drain");
    check("lat5_first", 64'(pop_cyc5.size() > 0 ? pop_cyc5[0] : -1), 64'(acc + 3));
    check("pad_pops",   64'(pop_cyc5.size()), 64'd3);

    // Backpressure: 3 items in flight, consumer stalled for 5 cycles
    out_ready8 = 1'b0;
    pop_cyc8.delete();
    push8(8'h01, OP_OR,  2'b01);
    push8(8'h0F, OP_AND, 2'b00);
    push8(8'h01, OP_XOR, 2'b01);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_in_ready",  64'(in_ready8),  64'd0);
      check("stall_out_valid", 64'(out_valid8), 64'd1);
      check("stall_out_y",     64'(out_y8),     64'd1);
      check("stall_out_err",   64'(out_err8),   64'd0);
      @(negedge clk);
    end
    out_ready8 = 1'b1;
    drain("stall_drain");
    check("stall_pops", 64'(pop_cyc8.size()), 64'd3);

    // Reset mid-stream with 2 items in flight
    out_ready8 = 1'b0;
    push8(8'h01, OP_OR,  2'b01);
    push8(8'hFF, OP_AND, 2'b01);
    @(negedge clk); #1;
    check("rst_pre_valid", 64'(out_valid8), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_out_valid", 64'(out_valid8), 64'd0);
    check("rst_async_out_y",     64'(out_y8),     64'd0);
    check("rst_async_out_err",   64'(out_err8),   64'd0);
    check("rst_async_in_ready",  64'(in_ready8),  64'd1);
    exp_q8.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready8 = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk); #1;
      if (out_valid8) seen = 1'b1;
    end
    check("rst_no_output", 64'(seen), 64'd0);

    // Randomized traffic on both instances against the model
    pend8 = 1'b0;
    pend5 = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      out_ready8 = ($urandom_range(0, 3) != 0);
      out_ready5 = ($urandom_range(0, 3) != 0);
      if (!pend8) begin
        if ($urandom_range(0, 3) != 0) begin
          in_valid8 = 1'b1; in_data8 = 8'($urandom); in_op8 = 3'($urandom_range(0, 7));
          pend8 = 1'b1;
        end else in_valid8 = 1'b0;
      end
      if (!pend5) begin
        if ($urandom_range(0, 3) != 0) begin
          in_valid5 = 1'b1; in_data5 = 5'($urandom); in_op5 = 3'($urandom_range(0, 7));
          pend5 = 1'b1;
        end else in_valid5 = 1'b0;
      end
      #1;
      if (pend8 && in_ready8) begin
        exp_q8.push_back(model(64'(in_data8), 8, in_op8));
        pend8 = 1'b0;
      end
      if (pend5 && in_ready5) begin
        exp_q5.push_back(model(64'(in_data5), 5, in_op5));
        pend5 = 1'b0;
      end
    end
    @(negedge clk);
    in_valid8 = 1'b0; in_valid5 = 1'b0;
    out_ready8 = 1'b1; out_ready5 = 1'b1;
    drain("random_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_reduce_pipe.md
Name: logic_reduce_pipe

Overview:
- Parametrised, pipelined N-input reduction gate: the registered, multi-function successor to the 2-input primitives (or2 and related cells).
- Reduces a WIDTH-bit vector with OR, AND, XOR, NOR, NAND or XNOR, selected per transaction.
- Built as a binary tree of 2-input gates with one register level per tree level.
- Valid/ready handshake on both sides; used as a reusable lab/library primitive in front of checkers and flag logic.

Parameters:
- WIDTH, 8, number of input bits; legal range 2..64.
- S (derived, localparam), clog2(WIDTH), number of pipeline stages (WIDTH=8 gives 3; WIDTH=5 gives 3; WIDTH=2 gives 1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts the input this cycle.
- in_data  in  WIDTH  vector to reduce.
- in_op  in  3  operation: 0 OR, 1 AND, 2 XOR, 3 NOR, 4 NAND, 5 XNOR, 6/7 illegal.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_y  out  1  reduction result.
- out_err  out  1  result came from an illegal op.

Behaviour:
- One clock domain (clk). rst is asynchronous and active-high.
- Reset: all stage valid bits, data, op and err registers clear immediately on rst assertion, without waiting for a clock edge.
  - Outputs during and after reset: out_valid=0, out_y=0, out_err=0, in_ready=1.
  - Reset asserted mid-operation discards all in-flight items; nothing is emitted after release.
- Advance enable: adv = !out_valid || out_ready.
  - Pipeline movement is global: on adv, every stage loads from its predecessor, and stage 1 loads from the inputs.
  - in_ready = adv, combinational. An input is accepted when in_valid && in_ready.
  - Bubbles are not collapsed.
- Latency: S clock edges from acceptance to out_valid=1 with no stall. Throughput: 1 item per cycle.
- Stage k: pairs adjacent bits of the level-(k-1) vector through 2-input gates of the base function (OR, AND or XOR). The width shrinks to ceil(w/2).
  - An odd leftover bit is paired with the identity element: 0 for OR/XOR, 1 for AND.
  - Each stage carries its valid bit, op and err alongside the data.
- Final stage: applies inversion for NOR/NAND/XNOR before the register, so out_y is registered and glitch-free.
- Illegal op (6/7): the item still flows through the pipeline. The result is out_y=0, out_err=1.
- Stall: while out_valid=1 && out_ready=0, out_y, out_err and all stages hold exactly.
  - No item is lost or duplicated, and order is preserved.
- Simultaneous events:
  - Acceptance and output pop in the same cycle are legal.
  - in_valid while in_ready=0 has no effect; the source must hold its data.
- in_data and in_op are sampled only on acceptance; X on these inputs when in_valid=0 must not propagate to out_y.

Decomposition:
- Package logic_reduce_pkg:
  - op encoding constants: OP_OR, OP_AND, OP_XOR, OP_NOR, OP_NAND, OP_XNOR.
  - function base_op(op) returning the 2-input gate type.
  - function invert_op(op) returning the final inversion flag.
  - function identity(op) returning the pad bit.
  - function clog2.
- Sub-module reduce_stage (params IN_W): one tree level of 2-input gates with padding, plus its register. Ports: clk, rst, en, vector, valid, op, err in and out. The top generates S instances.

Test Plan:
- Reset: WIDTH=8, assert rst mid-stream with 2 items in flight -> out_valid=0, out_y=0, in_ready=1 before the next clk edge; no outputs after release.
- OR sweep: WIDTH=8, op 0, data 8'h00, 8'h01, 8'h80 accepted back-to-back -> out_y 0, 1, 1 on 3 consecutive cycles starting 3 cycles after the first acceptance.
- Mixed ops: AND 8'hFF, NAND 8'hFF, XOR 8'h07, XNOR 8'h07, NOR 8'h00 back-to-back -> out_y 1, 0, 1, 0, 1 in order, out_err=0.
- Backpressure: hold out_ready=0 with 3 items in flight -> in_ready=0, out_valid=1 and out_y stable for 5 cycles; release -> 3 results in order, none duplicated.
- Padding: WIDTH=5 instance, AND 5'h1F, OR 5'h00, XOR 5'h10 -> out_y 1, 0, 1 with latency 3.
- Illegal op: WIDTH=8, op 3'd6, data 8'hFF -> out_valid=1, out_err=1, out_y=0. The following OR 8'h01 -> out_err=0, out_y=1.
